hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Stall/flush controller paired with the forwarding unit.
- Detects hazards that forwarding cannot cover: load-use, branch/JALR-on-load, and data-memory wait.
- Drives PC, IF/ID, ID/EX and EX/MEM enables, bubble and flush controls.
- Sequences multi-cycle stalls with an FSM and keeps saturating stall and flush counters.

Parameters:
CNT_W, 16, width of the performance counters stall_cycles and flush_count

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
rs1_ID  input  5  ID-stage source register 1
rs2_ID  input  5  ID-stage source register 2
use_rs1_ID  input  1  ID instruction reads rs1
use_rs2_ID  input  1  ID instruction reads rs2
is_branch_ID  input  1  ID instruction is a branch/JALR resolved in ID
redirect_ID  input  1  branch taken, JAL or JALR resolved in ID this cycle
rd_EX  input  5  EX-stage destination register
MemRead_EX  input  1  EX instruction is a load
rd_MEM  input  5  MEM-stage destination register
MemRead_MEM  input  1  MEM instruction is a load
mem_busy  input  1  data memory not ready; hold pipeline
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID to NOP
idex_bubble  output  1  insert NOP into ID/EX
exmem_hold  output  1  freeze EX/MEM and MEM/WB registers
stall_cycles  output  CNT_W  saturating count of stalled cycles
flush_count  output  CNT_W  saturating count of flushes

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = RUN; both counters = 0.
  - While rst_n is low, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0.
- Match terms (register x0 never matches):
  - mEX = rd_EX!=0 and ((use_rs1_ID and rd_EX==rs1_ID) or (use_rs2_ID and rd_EX==rs2_ID)).
  - mMEM is the same test using rd_MEM.
- FSM states and transitions:
  - RUN, evaluated in priority order:
    - mem_busy -> go to MEMWAIT, resume state = RUN.
    - is_branch_ID and MemRead_EX and mEX -> 2-cycle stall; next state BRSTALL2.
    - is_branch_ID and MemRead_MEM and mMEM -> 1-cycle stall; next state RUN.
    - MemRead_EX and mEX (non-branch) -> 1-cycle stall; next state RUN.
    - Otherwise advance normally.
  - BRSTALL2: stall one more cycle, then go to RUN. The load is then in WB, so WB-to-ID forwarding covers it.
  - MEMWAIT:
    - Held while mem_busy=1.
    - On mem_busy=0, return to the saved resume state and re-evaluate.
    - The saved resume state is RUN or BRSTALL2, captured on entry.
- Output encoding:
  - Stall cycle: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, exmem_hold=0.
  - Freeze (mem_busy=1, in any state): pc_write=0, ifid_write=0, idex_bubble=0, exmem_hold=1, ifid_flush=0. Nothing in the pipeline moves.
  - Normal cycle: pc_write=1, ifid_write=1, idex_bubble=0, exmem_hold=0, and ifid_flush=redirect_ID.
- Priority rules:
  - freeze > stall > flush.
  - redirect_ID asserted during a stall is ignored; the branch re-resolves with correct operands after the stall.
  - All control outputs are combinational from state and inputs, with zero latency.
- Counters:
  - stall_cycles increments on every stall or freeze cycle.
  - flush_count increments on every cycle where ifid_flush=1, excluding the reset-forced value.
  - Both saturate at all-ones.
- Reset mid-stall aborts the sequence; the FSM restarts in RUN.

Decomposition:
- Shared package pipeline_pkg holds:
  - the FSM state typedef (RUN, BRSTALL2, MEMWAIT);
  - REG_X0 = 5'd0;
  - a control-bundle struct {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}.
- One sub-module, sat_counter (parameter W, inputs inc and clear), instantiated twice.

Test Plan:
- Load-use: lw x5 in EX (MemRead_EX=1, rd_EX=5); ID add reads rs1=5 -> one cycle with pc_write=0 and idex_bubble=1, then normal; stall_cycles=1.
- Branch-on-load: lw x7 in EX; ID beq reads rs2=7 -> two stall cycles (RUN then BRSTALL2), third cycle normal; stall_cycles=2.
- Branch with load in MEM: MemRead_MEM=1, rd_MEM=3; ID branch reads rs1=3 -> exactly one stall cycle.
- x0 and unused operands:
  - lw x0 in EX with ID reading rs1=0 -> no stall.
  - lw x4 in EX with use_rs2_ID=0 and rs2_ID=4 -> no stall.
- mem_busy in BRSTALL2 held 3 cycles -> exmem_hold=1 for 3 cycles, then one BRSTALL2 cycle, then RUN; stall_cycles increments by 4 over this sequence.
- Redirect and saturation:
  - redirect_ID=1 in RUN with no hazard -> ifid_flush=1, flush_count+1.
  - redirect_ID=1 during a stall -> ifid_flush=0.
  - Counter preloaded to 0xFFFF -> remains at 0xFFFF.
  - rst_n low mid-stall -> immediate RUN and counters 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared stall-FSM states, control bundle and register-match helper.
package pipeline_pkg;
  typedef enum logic [1:0] {RUN, BRSTALL2, MEMWAIT} hs_state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_hold;
  } ctl_t;
  localparam ctl_t STALL_CTL  = 5'b00010;
  localparam ctl_t FREEZE_CTL = 5'b00001;
  localparam ctl_t RESET_CTL  = 5'b00110;
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic use1, input logic use2);
    return rd != REG_X0 && ((use1 && rd == rs1) || (use2 && rd == rs2));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch-on-load stall and memory-wait freeze controller.
module hazard_stall_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             is_branch_ID,
  input  logic             redirect_ID,
  input  logic [4:0]       rd_EX,
  input  logic             MemRead_EX,
  input  logic [4:0]       rd_MEM,
  input  logic             MemRead_MEM,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  hs_state_e state, resume, eff;
  ctl_t ctl, out;
  logic m_ex, m_mem, br2, stall;
  assign m_ex  = reg_match(rd_EX, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID);
  assign m_mem = reg_match(rd_MEM, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID);
  // MEMWAIT is transparent once memory is ready: behave as the saved state that same cycle
  assign eff   = (state == MEMWAIT) ? resume : state;
  assign br2   = is_branch_ID && MemRead_EX && m_ex;
  assign stall = !mem_busy && (eff == BRSTALL2 || br2 || (is_branch_ID && MemRead_MEM && m_mem) ||
                               (MemRead_EX && m_ex));
  assign ctl = mem_busy ? FREEZE_CTL :
               stall    ? STALL_CTL  :
               '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: redirect_ID, idex_bubble: 1'b0, exmem_hold: 1'b0};
  assign out = rst_n ? ctl : RESET_CTL;
  assign pc_write    = out.pc_write;
  assign ifid_write  = out.ifid_write;
  assign ifid_flush  = out.ifid_flush;
  assign idex_bubble = out.idex_bubble;
  assign exmem_hold  = out.exmem_hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= RUN;
      resume <= RUN;
    end else if (mem_busy) begin
      state  <= MEMWAIT;
      resume <= eff;
    end else begin
      state  <= (eff == RUN && br2) ? BRSTALL2 : RUN;
      resume <= RUN;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(mem_busy || stall), .clear(1'b0), .count(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ctl.ifid_flush), .clear(1'b0), .count(flush_count)
  );
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed + random check of the stall unit against a cycle-level model.
module tb_hazard_stall_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX, rd_MEM;
  logic        use_rs1_ID, use_rs2_ID, is_branch_ID, redirect_ID, MemRead_EX, MemRead_MEM, mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
  logic [15:0] stall_cycles, flush_count;
  int n_tests = 0, n_fail = 0;
  int pend = 0, m_stall = 0, m_flush = 0;
  int s0, f0, hold_cnt;
  logic [4:0] last_ctl;

  hazard_stall_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID),
    .use_rs2_ID(use_rs2_ID), .is_branch_ID(is_branch_ID), .redirect_ID(redirect_ID), .rd_EX(rd_EX),
    .MemRead_EX(MemRead_EX), .rd_MEM(rd_MEM), .MemRead_MEM(MemRead_MEM), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_hold(exmem_hold), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                       input logic brn, input logic rdr, input logic [4:0] de, input logic le,
                       input logic [4:0] dm, input logic lm, input logic bz);
    rs1_ID = a; rs2_ID = b; use_rs1_ID = ua; use_rs2_ID = ub; is_branch_ID = brn; redirect_ID = rdr;
    rd_EX = de; MemRead_EX = le; rd_MEM = dm; MemRead_MEM = lm; mem_busy = bz;
  endtask

  // One cycle: compare outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic me, mm, st, fz, fl;
    logic [4:0] exp_ctl;
    #1;
    me = rd_EX != 0 && ((use_rs1_ID && rd_EX == rs1_ID) || (use_rs2_ID && rd_EX == rs2_ID));
    mm = rd_MEM != 0 && ((use_rs1_ID && rd_MEM == rs1_ID) || (use_rs2_ID && rd_MEM == rs2_ID));
    fz = mem_busy;
    st = !mem_busy && (pend != 0 || (MemRead_EX && me) || (is_branch_ID && MemRead_MEM && mm));
    fl = !fz && !st && redirect_ID;
    exp_ctl = {!fz && !st, !fz && !st, fl, st, fz};
    last_ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold};
    chk("ctl", {27'd0, last_ctl}, {27'd0, exp_ctl});
    chk("stall_cycles", {16'd0, stall_cycles}, m_stall);
    chk("flush_count", {16'd0, flush_count}, m_flush);
    @(posedge clk);
    if (!mem_busy) pend = (pend != 0) ? 0 : int'(is_branch_ID && MemRead_EX && me);
    if ((fz || st) && m_stall < 65535) m_stall++;
    if (fl && m_flush < 65535) m_flush++;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_ctl", {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}, 32'b00110);
    chk("reset_stall_cnt", {16'd0, stall_cycles}, 0);
    chk("reset_flush_cnt", {16'd0, flush_count}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    // load-use on rs1
    s0 = m_stall;
    drive(5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(5, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0); step();
    idle();
    chk("loaduse_delta", {16'd0, stall_cycles} - s0, 1);
    // branch on load in EX: two stalls
    s0 = stall_cycles;
    drive(0, 7, 0, 1, 1, 0, 7, 1, 0, 0, 0); step();
    drive(0, 7, 0, 1, 1, 0, 0, 0, 7, 1, 0); step();
    drive(0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    chk("brload_delta", {16'd0, stall_cycles} - s0, 2);
    chk("brload_third_normal", {31'd0, last_ctl[4]}, 1);
    // branch with load in MEM: one stall
    s0 = stall_cycles;
    drive(3, 0, 1, 0, 1, 0, 0, 0, 3, 1, 0); step();
    drive(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step();
    chk("brmem_delta", {16'd0, stall_cycles} - s0, 1);
    // x0 destination and unused operand
    s0 = stall_cycles;
    drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0); step();
    drive(0, 4, 0, 0, 0, 0, 4, 1, 0, 0, 0); step();
    chk("x0_unused_delta", {16'd0, stall_cycles} - s0, 0);
    // mem_busy while in BRSTALL2
    drive(0, 7, 0, 1, 1, 0, 7, 1, 0, 0, 0); step();
    s0 = stall_cycles; hold_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 7, 0, 1, 1, 1, 0, 0, 7, 1, 1); step();
      hold_cnt += int'(last_ctl[0]);
    end
    drive(0, 7, 0, 1, 1, 0, 0, 0, 7, 1, 0); step();
    chk("brstall2_after_wait", {31'd0, last_ctl[1]}, 1);
    idle();
    chk("busy_hold_cycles", hold_cnt, 3);
    chk("busy_delta", {16'd0, stall_cycles} - s0, 4);
    chk("busy_then_run", {31'd0, last_ctl[4]}, 1);
    // redirect in RUN vs during stall
    f0 = flush_count;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    idle();
    chk("redirect_flush_delta", {16'd0, flush_count} - f0, 1);
    drive(5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 0); step();
    chk("redirect_in_stall", {31'd0, last_ctl[2]}, 0);
    // reset mid branch stall
    drive(0, 7, 0, 1, 1, 0, 7, 1, 0, 0, 0); step();
    rst_n = 1'b0;
    #1;
    chk("midreset_ctl", {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}, 32'b00110);
    chk("midreset_stall_cnt", {16'd0, stall_cycles}, 0);
    chk("midreset_flush_cnt", {16'd0, flush_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pend = 0; m_stall = 0; m_flush = 0;
    drive(0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    chk("midreset_run", {31'd0, last_ctl[4]}, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 7) == 0));
      step();
    end
    // saturation of stall_cycles via a long freeze
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m_stall = 65535;
    chk("stall_saturated", {16'd0, stall_cycles}, 32'hFFFF);
    step();
    idle();
    chk("stall_still_saturated", {16'd0, stall_cycles}, 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
